// File: rtl/mc_controller_if.sv
`default_nettype none
// ============================================================================
// mc_controller_if : IR fields, memory handshake and datapath control lines
//                    of the multi-cycle Minisys controller.
// Revision 1.0
// ============================================================================
interface mc_controller_if #(
   parameter int CNT_W = 32
);
   logic [5:0]       Opcode;
   logic [5:0]       Function_opcode;
   logic             mem_ready;
   logic             MemReq;
   logic             IRWrite;
   logic             PCWrite;
   logic             PCWriteCond;
   logic             nBranch;
   logic [1:0]       PCSrc;
   logic [1:0]       RegDST;
   logic             ALUSrc;
   logic             MemWrite;
   logic             MemtoReg;
   logic             RegWrite;
   logic             Sftmd;
   logic             I_format;
   logic             Jr;
   logic             Jmp;
   logic             Jal;
   logic [1:0]       ALUOp;
   logic [2:0]       state;
   logic [CNT_W-1:0] retired;
   logic             mem_timeout;
   logic             illegal_op;

   modport master (
      input  Opcode, Function_opcode, mem_ready,
      output MemReq, IRWrite, PCWrite, PCWriteCond, nBranch, PCSrc, RegDST,
             ALUSrc, MemWrite, MemtoReg, RegWrite, Sftmd, I_format, Jr, Jmp,
             Jal, ALUOp, state, retired, mem_timeout, illegal_op
   );

   modport slave (
      output Opcode, Function_opcode, mem_ready,
      input  MemReq, IRWrite, PCWrite, PCWriteCond, nBranch, PCSrc, RegDST,
             ALUSrc, MemWrite, MemtoReg, RegWrite, Sftmd, I_format, Jr, Jmp,
             Jal, ALUOp, state, retired, mem_timeout, illegal_op
   );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// mc_controller : multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//                 with memory wait timeout and retired-instruction counter.
//                 Optional macro MC_ILLEGAL_TRAP_EN traps illegal opcodes.
// Revision 1.0
// ============================================================================
module mc_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  wire logic       clock,
   input  wire logic       reset,
   mc_controller_if.master bus
);
   localparam int CW = $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] c_WAIT_LAST = CW'(MEM_TIMEOUT - 1);

   localparam logic [2:0] c_FETCH  = 3'd0;
   localparam logic [2:0] c_DECODE = 3'd1;
   localparam logic [2:0] c_EXEC   = 3'd2;
   localparam logic [2:0] c_MEM    = 3'd3;
   localparam logic [2:0] c_WB     = 3'd4;
   localparam logic [2:0] c_TRAP   = 3'd5;

   logic [2:0]       r_state, w_next;
   logic [CW-1:0]    r_wait;
   logic [CNT_W-1:0] r_retired;
   logic [5:0]       r_op, r_fn;
   logic             w_retire, w_timeout, w_ill;

   // DECODE works from the live IR; later phases use the latched copy
   logic w_d_j, w_d_jal, w_d_legal;
   assign w_d_j     = (bus.Opcode == 6'b000010);
   assign w_d_jal   = (bus.Opcode == 6'b000011);
   assign w_d_legal = (bus.Opcode == 6'b000000) || (bus.Opcode[5:3] == 3'b001) ||
                      (bus.Opcode == 6'b100011) || (bus.Opcode == 6'b101011) ||
                      (bus.Opcode == 6'b000100) || (bus.Opcode == 6'b000101) ||
                      w_d_j || w_d_jal;

   logic w_r, w_i, w_lw, w_sw, w_beq, w_bne, w_jr, w_sft;
   assign w_r   = (r_op == 6'b000000);
   assign w_i   = (r_op[5:3] == 3'b001);
   assign w_lw  = (r_op == 6'b100011);
   assign w_sw  = (r_op == 6'b101011);
   assign w_beq = (r_op == 6'b000100);
   assign w_bne = (r_op == 6'b000101);
   assign w_jr  = w_r && (r_fn == 6'b001000);
   assign w_sft = w_r && (r_fn[5:3] == 3'b000);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= c_FETCH;
         r_wait    <= '0;
         r_retired <= '0;
         r_op      <= '0;
         r_fn      <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) r_retired <= r_retired + CNT_W'(1);
         if (r_state == c_DECODE) begin
            r_op <= bus.Opcode;
            r_fn <= bus.Function_opcode;
         end
         if ((r_state == c_FETCH || r_state == c_MEM) && !bus.mem_ready && !w_timeout)
            r_wait <= r_wait + CW'(1);
         else
            r_wait <= '0;
      end
   end

`ifdef MC_ILLEGAL_TRAP_EN
   logic r_illegal;
   always_ff @(posedge clock) begin
      if (reset)
         r_illegal <= 1'b0;
      else if (r_state == c_DECODE && !w_d_legal)
         r_illegal <= 1'b1;
   end
   assign w_ill = r_illegal;
`else
   assign w_ill = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      w_retire  = 1'b0;
      w_timeout = 1'b0;
      case (r_state)
         c_FETCH, c_MEM: begin
            if (bus.mem_ready) begin
               if (r_state == c_FETCH) begin
                  w_next = c_DECODE;
               end else if (w_sw) begin
                  w_next   = c_FETCH;
                  w_retire = 1'b1;
               end else begin
                  w_next = c_WB;
               end
            end else if (r_wait == c_WAIT_LAST) begin
               w_timeout = 1'b1;
               w_next    = c_FETCH;
            end
         end
         c_DECODE: begin
            if (w_d_j || w_d_jal) begin
               w_next   = c_FETCH;
               w_retire = 1'b1;
            end else if (!w_d_legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
               w_next   = c_TRAP;
`else
               w_next   = c_FETCH;
               w_retire = 1'b1;
`endif
            end else begin
               w_next = c_EXEC;
            end
         end
         c_EXEC: begin
            if (w_beq || w_bne || w_jr) begin
               w_next   = c_FETCH;
               w_retire = 1'b1;
            end else if (w_lw || w_sw) begin
               w_next = c_MEM;
            end else begin
               w_next = c_WB;
            end
         end
         c_WB: begin
            w_next   = c_FETCH;
            w_retire = 1'b1;
         end
         c_TRAP:  w_next = c_TRAP;
         default: w_next = c_FETCH;
      endcase
   end

   logic       w_mem_req, w_ir_write, w_pc_write, w_pc_cond, w_nbranch;
   logic       w_alu_src, w_mem_write, w_mem_to_reg, w_reg_write, w_sftmd;
   logic       w_i_format, w_jr_o, w_jmp, w_jal;
   logic [1:0] w_pc_src, w_reg_dst, w_alu_op;

   always_comb begin
      w_mem_req    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_cond    = 1'b0;
      w_nbranch    = 1'b0;
      w_alu_src    = 1'b0;
      w_mem_write  = 1'b0;
      w_mem_to_reg = 1'b0;
      w_reg_write  = 1'b0;
      w_sftmd      = 1'b0;
      w_i_format   = 1'b0;
      w_jr_o       = 1'b0;
      w_jmp        = 1'b0;
      w_jal        = 1'b0;
      w_pc_src     = 2'b00;
      w_reg_dst    = 2'b00;
      w_alu_op     = 2'b00;
      case (r_state)
         c_FETCH: begin
            w_mem_req  = 1'b1;
            w_ir_write = bus.mem_ready;
            w_pc_write = bus.mem_ready;
         end
         c_DECODE: begin
            w_jmp = w_d_j;
            w_jal = w_d_jal;
            if (w_d_j || w_d_jal) begin
               w_pc_write = 1'b1;
               w_pc_src   = 2'b10;
            end
            if (w_d_jal) begin
               w_reg_write = 1'b1;
               w_reg_dst   = 2'b10;
            end
         end
         c_EXEC, c_MEM, c_WB: begin
            // ALU controls stay stable across the whole post-decode sequence
            w_alu_src  = w_i || w_lw || w_sw;
            w_alu_op   = {w_r || w_i, w_beq || w_bne};
            w_sftmd    = w_sft;
            w_i_format = w_i;
            if (r_state == c_EXEC) begin
               w_pc_cond = w_beq;
               w_nbranch = w_bne;
               w_jr_o    = w_jr;
               w_pc_write = w_jr;
               if (w_beq || w_bne) w_pc_src = 2'b01;
               else if (w_jr)      w_pc_src = 2'b11;
            end else if (r_state == c_MEM) begin
               w_mem_req   = 1'b1;
               w_mem_write = w_sw;
            end else begin
               w_reg_write  = 1'b1;
               w_mem_to_reg = w_lw;
               w_reg_dst    = w_r ? 2'b01 : 2'b00;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.MemReq      = w_mem_req    & ~reset;
   assign bus.IRWrite     = w_ir_write   & ~reset;
   assign bus.PCWrite     = w_pc_write   & ~reset;
   assign bus.PCWriteCond = w_pc_cond    & ~reset;
   assign bus.nBranch     = w_nbranch    & ~reset;
   assign bus.ALUSrc      = w_alu_src    & ~reset;
   assign bus.MemWrite    = w_mem_write  & ~reset;
   assign bus.MemtoReg    = w_mem_to_reg & ~reset;
   assign bus.RegWrite    = w_reg_write  & ~reset;
   assign bus.Sftmd       = w_sftmd      & ~reset;
   assign bus.I_format    = w_i_format   & ~reset;
   assign bus.Jr          = w_jr_o       & ~reset;
   assign bus.Jmp         = w_jmp        & ~reset;
   assign bus.Jal         = w_jal        & ~reset;
   assign bus.mem_timeout = w_timeout    & ~reset;
   assign bus.illegal_op  = w_ill        & ~reset;
   assign bus.PCSrc       = reset ? 2'b00 : w_pc_src;
   assign bus.RegDST      = reset ? 2'b00 : w_reg_dst;
   assign bus.ALUOp       = reset ? 2'b00 : w_alu_op;
   assign bus.state       = reset ? 3'b000 : r_state;
   assign bus.retired     = reset ? '0 : r_retired;
endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// tb_mc_controller: per-cycle scoreboard of mc_controller outputs against an
// instruction-level phase model, driven by directed and random instruction streams.
module tb_mc_controller;
   localparam int MT = 4;
   localparam int CW = 32;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   mc_controller_if #(.CNT_W(CW)) bus();
   mc_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct packed {
      logic [2:0]    st;
      logic          MemReq, IRWrite, PCWrite, PCWriteCond, nBranch;
      logic [1:0]    PCSrc, RegDST;
      logic          ALUSrc, MemWrite, MemtoReg, RegWrite, Sftmd, I_format, Jr, Jmp, Jal;
      logic [1:0]    ALUOp;
      logic          mem_timeout, illegal_op;
      logic [CW-1:0] retired;
   } obs_t;

   obs_t          expq[$];
   string         tagq[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [CW-1:0] exp_ret = '0;
   logic          exp_ill = 1'b0;
   logic [5:0]    cur_op, cur_fn;
   string         cur_tag;
   bit            halt;
   int            cut_left;

   function automatic obs_t base(input logic [2:0] st);
      obs_t e;
      e = '0;
      e.st = st;
      e.illegal_op = exp_ill;
      e.retired = exp_ret;
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t a;
      a.st = bus.state;             a.MemReq = bus.MemReq;
      a.IRWrite = bus.IRWrite;      a.PCWrite = bus.PCWrite;
      a.PCWriteCond = bus.PCWriteCond; a.nBranch = bus.nBranch;
      a.PCSrc = bus.PCSrc;          a.RegDST = bus.RegDST;
      a.ALUSrc = bus.ALUSrc;        a.MemWrite = bus.MemWrite;
      a.MemtoReg = bus.MemtoReg;    a.RegWrite = bus.RegWrite;
      a.Sftmd = bus.Sftmd;          a.I_format = bus.I_format;
      a.Jr = bus.Jr;                a.Jmp = bus.Jmp;
      a.Jal = bus.Jal;              a.ALUOp = bus.ALUOp;
      a.mem_timeout = bus.mem_timeout; a.illegal_op = bus.illegal_op;
      a.retired = bus.retired;
      return a;
   endfunction

   // monitor: every cycle that has an expectation queued is compared
   always @(negedge clock) begin
      if (expq.size() > 0) begin
         obs_t e;
         obs_t a;
         string t;
         e = expq.pop_front();
         t = tagq.pop_front();
         a = sample();
         n_cmp++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL %s @%0t: actual=%h required=%h", t, $time, a, e);
         end
      end
   end

   task automatic cyc(input logic rst, input logic rdy, input logic [5:0] op,
                      input logic [5:0] fn, input obs_t e, input string tag);
      @(posedge clock);
      #1;
      reset = rst;
      bus.mem_ready = rdy;
      bus.Opcode = op;
      bus.Function_opcode = fn;
      expq.push_back(e);
      tagq.push_back(tag);
   endtask

   task automatic emit(input logic rdy, input obs_t e, input bit ret);
      if (halt) return;
      cyc(1'b0, rdy, cur_op, cur_fn, e, cur_tag);
      if (ret) exp_ret = exp_ret + 1;
      if (cut_left > 0) begin
         cut_left--;
         if (cut_left == 0) halt = 1'b1;
      end
   endtask

   task automatic do_reset(input int n);
      exp_ret = '0;
      exp_ill = 1'b0;
      for (int i = 0; i < n; i++)
         cyc(1'b1, 1'b1, 6'($urandom), 6'($urandom), '0, "reset");
   endtask

   // Instruction-level model: fw/mw are wait cycles before mem_ready in FETCH/MEM;
   // a wait of MT or more means no ready before the abort. cut>0 stops after cut cycles.
   task automatic do_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                           input int mw, input int cut, input string tag);
      obs_t e;
      bit r, i, lw, sw, beq, bne, j, jal, jr, sft, legal;
      logic rr;
      halt = 1'b0; cut_left = cut;
      cur_op = op; cur_fn = fn; cur_tag = tag;
      r = (op == 6'd0); i = (op[5:3] == 3'b001);
      lw = (op == 6'd35); sw = (op == 6'd43); beq = (op == 6'd4); bne = (op == 6'd5);
      j = (op == 6'd2); jal = (op == 6'd3);
      jr = r && (fn == 6'd8); sft = r && (fn[5:3] == 3'b000);
      legal = r || i || lw || sw || beq || bne || j || jal;

      e = base(3'd0);
      e.MemReq = 1'b1;
      if (fw >= MT) begin
         for (int k = 0; k < MT; k++) begin
            e.mem_timeout = (k == MT - 1);
            emit(1'b0, e, 1'b0);
         end
         return;
      end
      for (int k = 0; k < fw; k++) emit(1'b0, e, 1'b0);
      e.IRWrite = 1'b1; e.PCWrite = 1'b1;
      emit(1'b1, e, 1'b0);

      rr = 1'($urandom);
      e = base(3'd1);
      if (j || jal) begin
         e.PCWrite = 1'b1; e.PCSrc = 2'b10; e.Jmp = j; e.Jal = jal;
         if (jal) begin e.RegWrite = 1'b1; e.RegDST = 2'b10; end
         emit(rr, e, 1'b1);
         return;
      end
      if (!legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
         emit(rr, e, 1'b0);
         exp_ill = 1'b1;
`else
         emit(rr, e, 1'b1);
`endif
         return;
      end
      emit(rr, e, 1'b0);

      rr = 1'($urandom);
      e = base(3'd2);
      e.ALUSrc = i || lw || sw; e.ALUOp = {r || i, beq || bne};
      e.Sftmd = sft; e.I_format = i;
      if (beq || bne || jr) begin
         e.PCWriteCond = beq; e.nBranch = bne; e.Jr = jr; e.PCWrite = jr;
         e.PCSrc = jr ? 2'b11 : 2'b01;
         emit(rr, e, 1'b1);
         return;
      end
      emit(rr, e, 1'b0);

      if (lw || sw) begin
         e.st = 3'd3; e.MemReq = 1'b1; e.MemWrite = sw;
         if (mw >= MT) begin
            for (int k = 0; k < MT; k++) begin
               e.mem_timeout = (k == MT - 1);
               emit(1'b0, e, 1'b0);
            end
            return;
         end
         for (int k = 0; k < mw; k++) emit(1'b0, e, 1'b0);
         emit(1'b1, e, sw);
         if (sw) return;
      end

      e = base(3'd4);
      e.ALUSrc = i || lw || sw; e.ALUOp = {r || i, beq || bne};
      e.Sftmd = sft; e.I_format = i;
      e.RegWrite = 1'b1; e.MemtoReg = lw; e.RegDST = r ? 2'b01 : 2'b00;
      emit(1'($urandom), e, 1'b1);
   endtask

   function automatic int pick_wait();
      int k;
      k = $urandom_range(0, 9);
      if (k < 5) return 0;
      if (k < 8) return $urandom_range(1, 2);
      if (k == 8) return MT - 1;
      return MT;
   endfunction

   task automatic pick(output logic [5:0] op, output logic [5:0] fn, output string tag);
      logic [5:0] ill [5];
      int k;
      ill = '{6'b111111, 6'b100000, 6'b010000, 6'b000001, 6'b000110};
      k = $urandom_range(0, 10);
      fn = 6'($urandom);
      op = 6'd0;
      tag = "rnd_R";
      case (k)
         0: fn = {1'b1, fn[4:0]};
         1: begin fn = 6'b001000; tag = "rnd_jr"; end
         2: begin fn = {3'b000, fn[2:0]}; tag = "rnd_shift"; end
         3: begin op = {3'b001, 3'($urandom)}; tag = "rnd_I"; end
         4: begin op = 6'd35; tag = "rnd_lw"; end
         5: begin op = 6'd43; tag = "rnd_sw"; end
         6: begin op = 6'd4;  tag = "rnd_beq"; end
         7: begin op = 6'd5;  tag = "rnd_bne"; end
         8: begin op = 6'd2;  tag = "rnd_j"; end
         9: begin op = 6'd3;  tag = "rnd_jal"; end
         default: begin
`ifndef MC_ILLEGAL_TRAP_EN
            op = ill[$urandom_range(0, 4)];
            tag = "rnd_illegal";
`else
            fn = {1'b1, fn[4:0]};
`endif
         end
      endcase
   endtask

   initial begin
      logic [5:0] op, fn;
      string tag;
      bus.mem_ready = 1'b1;
      bus.Opcode = '0;
      bus.Function_opcode = '0;

      do_reset(2);
      do_instr(6'd0,  6'b100000, 0, 0, 0, "add");
      do_instr(6'd35, 6'd0, 0, 3, 0, "lw_wait3");
      do_instr(6'd43, 6'd0, 0, 0, 0, "sw");
      do_instr(6'd3,  6'd0, 0, 0, 0, "jal");
      do_instr(6'd0,  6'b001000, 0, 0, 0, "jr");
      do_instr(6'd0,  6'b100000, MT, 0, 0, "fetch_timeout");
      do_instr(6'd0,  6'b100000, MT - 1, 0, 0, "fetch_ready_last");
      do_instr(6'd35, 6'd0, 1, MT, 0, "mem_timeout");
      do_instr(6'd43, 6'd0, 0, MT - 1, 0, "mem_ready_last");
      do_instr(6'd4,  6'd0, 0, 0, 0, "beq");
      do_instr(6'd5,  6'd0, 0, 0, 0, "bne");
      do_instr(6'd2,  6'd0, 0, 0, 0, "j");
      do_instr(6'd0,  6'b000010, 0, 0, 0, "srl");
      do_instr(6'b001101, 6'd0, 0, 0, 0, "ori");
`ifndef MC_ILLEGAL_TRAP_EN
      do_instr(6'b111111, 6'd0, 0, 0, 0, "illegal_nop");
`endif

      for (int n = 0; n < 200; n++) begin
         pick(op, fn, tag);
         do_instr(op, fn, pick_wait(), pick_wait(), 0, tag);
      end

      do_instr(6'd35, 6'd0, 0, 2, 4, "lw_cut");
      do_reset(2);
      do_instr(6'd0, 6'b100001, 0, 0, 0, "add_after_reset");

`ifdef MC_ILLEGAL_TRAP_EN
      do_instr(6'b111111, 6'd0, 0, 0, 0, "illegal_trap");
      for (int k = 0; k < 4; k++)
         cyc(1'b0, 1'($urandom), 6'($urandom), 6'($urandom), base(3'd5), "trap_hold");
      do_reset(2);
      do_instr(6'd43, 6'd0, 0, 0, 0, "sw_after_trap");
`endif

      repeat (3) @(posedge clock);
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL drain: actual=%0d pending required=0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
